// File: rtl/vend_pkg.sv
// ============================================================================
// Module : vend_pkg
// Brief  : Shared types and constants for the vending machine controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_COLLECT  = 3'b001,
        ST_DISPENSE = 3'b010,
        ST_CHANGE   = 3'b011,
        ST_REFUND   = 3'b100
    } state_t;

    localparam int COIN_VAL_W = 5;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    localparam logic [COIN_VAL_W-1:0] VAL_NICKEL  = 5'd5;
    localparam logic [COIN_VAL_W-1:0] VAL_DIME    = 5'd10;
    localparam logic [COIN_VAL_W-1:0] VAL_QUARTER = 5'd25;

    localparam int NICKEL = 5;

endpackage

`default_nettype wire

// File: rtl/vend_controller_if.sv
// ============================================================================
// Module : vend_controller_if
// Brief  : Front-panel strobes in, machine status and actuator pulses out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface vend_controller_if #(
    parameter int CREDIT_W = 8
);
    logic                coin_valid;
    logic [1:0]          coin;
    logic                sel_valid;
    logic [1:0]          sel;
    logic                cancel;
    logic [2:0]          state;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic [1:0]          item;
    logic                change_nickel;
    logic                coin_reject;
    logic                sel_deny;

    modport master (
        output coin_valid, coin, sel_valid, sel, cancel,
        input  state, credit, dispense, item, change_nickel, coin_reject, sel_deny
    );

    modport slave (
        input  coin_valid, coin, sel_valid, sel, cancel,
        output state, credit, dispense, item, change_nickel, coin_reject, sel_deny
    );
endinterface

`default_nettype wire

// File: rtl/vend_coin_decode.sv
// ============================================================================
// Module : coin_decode
// Brief  : Combinational coin code to cent value decode with validity flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module coin_decode
    import vend_pkg::*;
(
    input  wire logic                  coin_valid,
    input  wire logic [1:0]            coin,
    output logic      [COIN_VAL_W-1:0] value,
    output logic                       valid
);

    always_comb begin
        value = '0;
        valid = 1'b0;
        if (coin_valid) begin
            case (coin)
                COIN_NONE:    ;
                COIN_NICKEL:  begin value = VAL_NICKEL;  valid = 1'b1; end
                COIN_DIME:    begin value = VAL_DIME;    valid = 1'b1; end
                COIN_QUARTER: begin value = VAL_QUARTER; valid = 1'b1; end
                default:      ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/vend_controller.sv
// ============================================================================
// Module : vend_controller
// Brief  : Vending sequencer: credit tracking, dispense and change pulses.
//          Define VEND_CHANGE_EN to return leftover credit after a dispense.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE0     = 25,
    parameter int PRICE1     = 50,
    parameter int PRICE2     = 65,
    parameter int PRICE3     = 100,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200
) (
    input  wire logic         clk,
    input  wire logic         reset,
    vend_controller_if.slave  bus
);

    localparam int CW1 = CREDIT_W + 1;

    localparam logic [CW1-1:0]      P0        = CW1'(PRICE0);
    localparam logic [CW1-1:0]      P1        = CW1'(PRICE1);
    localparam logic [CW1-1:0]      P2        = CW1'(PRICE2);
    localparam logic [CW1-1:0]      P3        = CW1'(PRICE3);
    localparam logic [CW1-1:0]      MAX_C     = CW1'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(NICKEL);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [1:0]            item_q, item_d;
    logic                  reject_q, reject_d;
    logic                  deny_q, deny_d;

    logic [COIN_VAL_W-1:0] coin_value;
    logic                  coin_ok;
    logic [CW1-1:0]        credit_ext;
    logic [CW1-1:0]        credit_sum;
    logic [CW1-1:0]        price_sel;

    coin_decode u_coin_decode (
        .coin_valid (bus.coin_valid),
        .coin       (bus.coin),
        .value      (coin_value),
        .valid      (coin_ok)
    );

    // One extra bit so credit + coin can be compared against the ceiling without wrapping
    assign credit_ext = {1'b0, credit_q};
    assign credit_sum = credit_ext + CW1'(coin_value);

    always_comb begin
        case (bus.sel)
            2'd0:    price_sel = P0;
            2'd1:    price_sel = P1;
            2'd2:    price_sel = P2;
            default: price_sel = P3;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            item_q   <= 2'd0;
            reject_q <= 1'b0;
            deny_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            item_q   <= item_d;
            reject_q <= reject_d;
            deny_q   <= deny_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        item_d   = item_q;
        reject_d = 1'b0;
        deny_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (coin_ok) begin
                    credit_d = CREDIT_W'(coin_value);
                    state_d  = ST_COLLECT;
                end
                if (bus.sel_valid) deny_d = 1'b1;
            end
            ST_COLLECT: begin
                if (bus.cancel) begin
                    state_d  = ST_REFUND;
                    reject_d = coin_ok;
                end else if (bus.sel_valid) begin
                    reject_d = coin_ok;
                    if (credit_ext >= price_sel) begin
                        credit_d = CREDIT_W'(credit_ext - price_sel);
                        item_d   = bus.sel;
                        state_d  = ST_DISPENSE;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (coin_ok) begin
                    if (credit_sum <= MAX_C) credit_d = CREDIT_W'(credit_sum);
                    else                     reject_d = 1'b1;
                end
            end
            ST_DISPENSE: begin
                reject_d = coin_ok;
                if (credit_q != '0) begin
`ifdef VEND_CHANGE_EN
                    state_d = ST_CHANGE;
`else
                    state_d = ST_COLLECT;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                reject_d = coin_ok;
                if (credit_q != '0) credit_d = credit_q - NICKEL_C;
                // Credit is a multiple of 5, so <= 5 means this edge empties it
                if (credit_q <= NICKEL_C) state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    assign bus.state         = state_q;
    assign bus.credit        = credit_q;
    assign bus.item          = item_q;
    assign bus.dispense      = (state_q == ST_DISPENSE);
    assign bus.change_nickel = ((state_q == ST_CHANGE) || (state_q == ST_REFUND)) && (credit_q != '0);
    assign bus.coin_reject   = reject_q;
    assign bus.sel_deny      = deny_q;

endmodule

`default_nettype wire
